// File: rtl/data_cache.sv
// ---------------------------------------------------------------------------
// data_cache
//   Direct-mapped, write-back, write-allocate data cache between the cpu
//   load/store port and data_memory. Blocks are 4 bytes and move to and from
//   memory as one 32-bit word.
//
//   Address split (8-bit byte address): {tag, index, offset[1:0]}
//     index = INDEX_BITS bits, tag = 6 - INDEX_BITS bits.
//
//   Handshake (cpu side and memory side use the same READ/WRITE/BUSYWAIT
//   style): the requester raises READ or WRITE and holds it, together with
//   the address and write data, until the responder's BUSYWAIT is low at a
//   rising edge; that edge completes the transaction. A hit completes in the
//   cycle it is presented (BUSYWAIT never rises).
//
// Ports
//   CLK, RESET        clock; synchronous active-low reset
//   READ, WRITE       cpu load / store request (both high = store)
//   ADDRESS           cpu byte address
//   WRITEDATA         cpu store byte
//   READDATA          load byte (0 unless a read hit in IDLE)
//   BUSYWAIT          cpu stall
//   MEM_READ          block fetch request (registered)
//   MEM_WRITE         block write-back request (registered)
//   MEM_ADDRESS       block address {tag, index}
//   MEM_WRITEDATA     block being written back, byte 0 in [7:0]
//   MEM_READDATA      fetched block, byte 0 in [7:0]
//   MEM_BUSYWAIT      memory busy
//   o_dbg_state       current controller state (0 IDLE, 1 WRITEBACK, 2 FETCH)
// ---------------------------------------------------------------------------
module data_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT,
    output logic [1:0]  o_dbg_state
);

    localparam int SETS     = 1 << INDEX_BITS;
    localparam int TAG_BITS = 6 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH     = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_first;      // high during the first cycle of a memory transfer
    logic                  r_mem_read;
    logic                  r_mem_write;

    logic [SETS-1:0]       r_valid;
    logic [SETS-1:0]       r_dirty;
    logic [TAG_BITS-1:0]   r_tag  [SETS];
    logic [31:0]           r_data [SETS];

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic [1:0]            w_offset;
    logic [4:0]            w_bit;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_done;
    logic [31:0]           w_block;
    logic [7:0]            w_byte;

    assign w_index  = ADDRESS[2 +: INDEX_BITS];
    assign w_tag    = ADDRESS[7 -: TAG_BITS];
    assign w_offset = ADDRESS[1:0];
    assign w_bit    = {w_offset, 3'b000};
    assign w_req    = READ | WRITE;
    assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_block  = r_data[w_index];
    assign w_byte   = w_block[w_bit +: 8];

    // Memory drives a registered busy, so at the first edge of a transfer
    // MEM_BUSYWAIT still shows the idle value and must not be trusted.
    assign w_done   = !r_first && !MEM_BUSYWAIT;

    // cpu side, combinational so a hit costs no cycle
    assign BUSYWAIT = (r_state != S_IDLE) | (w_req & !w_hit);
    assign READDATA = (r_state == S_IDLE && READ && !WRITE && w_hit) ? w_byte : 8'h00;

    // memory side
    assign MEM_READ      = r_mem_read;
    assign MEM_WRITE     = r_mem_write;
    assign MEM_ADDRESS   = (r_state == S_WRITEBACK) ? {r_tag[w_index], w_index}
                                                    : {w_tag, w_index};
    assign MEM_WRITEDATA = w_block;
    assign o_dbg_state   = r_state;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_valid     <= '0;
            r_dirty     <= '0;
            r_state     <= S_IDLE;
            r_first     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (WRITE && w_hit) begin
                        r_data[w_index][w_bit +: 8] <= WRITEDATA;
                        r_dirty[w_index]            <= 1'b1;
                    end else if (w_req && !w_hit) begin
                        r_first <= 1'b1;
                        if (r_valid[w_index] && r_dirty[w_index]) begin
                            r_state     <= S_WRITEBACK;
                            r_mem_write <= 1'b1;
                        end else begin
                            r_state    <= S_FETCH;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                S_WRITEBACK: begin
                    r_first <= 1'b0;
                    if (w_done) begin
                        // hand straight over to the fetch; request lines swap on one edge
                        r_state     <= S_FETCH;
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b1;
                        r_first     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_first <= 1'b0;
                    if (w_done) begin
                        r_data[w_index]  <= MEM_READDATA;
                        r_tag[w_index]   <= w_tag;
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                        r_state          <= S_IDLE;
                        r_mem_read       <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_first     <= 1'b0;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// ---------------------------------------------------------------------------
// tb_data_cache
//   Bench for data_cache. The reference is a flat 256-byte memory (what the
//   cpu must always read back) plus a per-set record of which block is
//   resident and whether it has been stored to since it was fetched.
// ---------------------------------------------------------------------------
module tb_data_cache;

    // ---------------- clock / reset ----------------
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = 8'h00;
    logic [7:0]  WRITEDATA = 8'h00;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA = 32'h0;
    logic        MEM_BUSYWAIT = 1'b0;
    logic [1:0]  o_dbg_state;

    always #5 CLK = ~CLK;

    data_cache #(.INDEX_BITS(3)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT),
        .o_dbg_state   (o_dbg_state)
    );

    // ---------------- main memory model ----------------
    // Busy is registered: it rises on the edge after a new request appears,
    // stays high mem_lat cycles, and the data is moved when it falls.
    logic [31:0] backing [64];
    int          mem_lat = 5;
    int          mem_cnt = 0;
    logic [1:0]  prev_req = 2'b00;

    always @(posedge CLK) begin
        if ({MEM_READ, MEM_WRITE} == 2'b00) begin
            MEM_BUSYWAIT <= 1'b0;
            mem_cnt      <= 0;
        end else if ({MEM_READ, MEM_WRITE} != prev_req) begin
            MEM_BUSYWAIT <= 1'b1;
            mem_cnt      <= mem_lat;
        end else if (MEM_BUSYWAIT) begin
            if (mem_cnt <= 1) begin
                MEM_BUSYWAIT <= 1'b0;
                if (MEM_WRITE) backing[MEM_ADDRESS] <= MEM_WRITEDATA;
                else           MEM_READDATA <= backing[MEM_ADDRESS];
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end
        prev_req <= {MEM_READ, MEM_WRITE};
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [256];
    logic        m_valid [8];
    logic        m_dirty [8];
    logic [2:0]  m_tag   [8];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  last_rdata;
    logic [5:0]  last_wb_addr;
    logic [31:0] last_wb_data;
    logic [5:0]  last_fa;
    logic        last_saw_wr;
    logic        last_saw_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_block(input logic [5:0] blk);
        logic [31:0] b;
        for (int k = 0; k < 4; k++) b[8*k +: 8] = ref_mem[{blk, 2'(k)}];
        return b;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
        // dirty lines are lost on reset; the cpu view falls back to memory
        for (int i = 0; i < 256; i++) ref_mem[i] = backing[i >> 2][8*(i & 3) +: 8];
    endtask

    // ---------------- driver ----------------
    task automatic drop_req();
        @(negedge CLK);
        READ  = 1'b0;
        WRITE = 1'b0;
    endtask

    // Present one access, follow it to completion and score it. Returns with
    // the request still asserted just before the completing edge.
    task automatic do_access(input bit wr, input bit both, input logic [7:0] a, input logic [7:0] d);
        logic [2:0] idx;
        logic [2:0] tg;
        bit         hit_exp;
        bit         dirty_exp;
        bit         overlap;
        int         cycles;
        idx = a[4:2];
        tg  = a[7:5];
        @(negedge CLK);
        READ      = !wr | both;
        WRITE     = wr;
        ADDRESS   = a;
        WRITEDATA = d;
        #1;
        hit_exp   = m_valid[idx] && (m_tag[idx] == tg);
        dirty_exp = m_valid[idx] && m_dirty[idx];
        check("stall_on_issue", BUSYWAIT, !hit_exp);
        last_saw_wr = 1'b0;
        last_saw_rd = 1'b0;
        overlap     = 1'b0;
        cycles      = 0;
        while (BUSYWAIT && cycles < 200) begin
            if (MEM_WRITE) begin
                last_saw_wr  = 1'b1;
                last_wb_addr = MEM_ADDRESS;
                last_wb_data = MEM_WRITEDATA;
            end
            if (MEM_READ) begin
                last_saw_rd = 1'b1;
                last_fa     = MEM_ADDRESS;
            end
            if (MEM_READ && MEM_WRITE) overlap = 1'b1;
            @(negedge CLK);
            #1;
            cycles++;
        end
        if (cycles >= 200) check("miss_timeout", 1, 0);
        check("mem_rd_wr_overlap", overlap, 0);
        check("fetch_seen", last_saw_rd, !hit_exp);
        check("writeback_seen", last_saw_wr, !hit_exp && dirty_exp);
        if (last_saw_wr && !hit_exp && dirty_exp) begin
            check("wb_addr", last_wb_addr, {m_tag[idx], idx});
            check("wb_data", last_wb_data, ref_block({m_tag[idx], idx}));
        end
        if (last_saw_rd && !hit_exp) check("fetch_addr", last_fa, a[7:2]);
        check("idle_mem_lines", {MEM_READ, MEM_WRITE}, 2'b00);
        last_rdata = READDATA;
        check("readdata", READDATA, wr ? 8'h00 : ref_mem[a]);
        // model update for what the completing edge will do
        if (!hit_exp) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            ref_mem[a]   = d;
            m_dirty[idx] = 1'b1;
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        int guard;
        for (int b = 0; b < 64; b++) backing[b] = $urandom;
        backing[1] = 32'h44332211;
        model_reset();

        // reset
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busywait", BUSYWAIT, 0);
        check("rst_mem_lines", {MEM_READ, MEM_WRITE}, 2'b00);
        check("rst_readdata", READDATA, 8'h00);
        check("rst_state", o_dbg_state, 2'd0);
        @(negedge CLK);
        RESET = 1'b1;

        // directed plan, 5-cycle memory
        mem_lat = 5;
        do_access(0, 0, 8'h05, 8'h00);
        check("plan_fill_addr", last_fa, 6'h01);
        check("plan_rd05", last_rdata, 8'h22);
        do_access(0, 0, 8'h05, 8'h00);
        check("plan_rd05_hit", last_rdata, 8'h22);
        do_access(0, 0, 8'h07, 8'h00);
        check("plan_rd07_hit", last_rdata, 8'h44);
        do_access(1, 0, 8'h05, 8'hAB);
        do_access(0, 0, 8'h05, 8'h00);
        check("plan_rd05_after_wr", last_rdata, 8'hAB);
        do_access(0, 0, 8'h25, 8'h00);
        check("plan_wb_addr", last_wb_addr, 6'h01);
        check("plan_wb_data", last_wb_data, 32'h4433AB11);
        check("plan_refetch_addr", last_fa, 6'h09);
        do_access(1, 0, 8'h80, 8'h77);
        check("plan_clean_miss_no_wb", last_saw_wr, 0);
        do_access(0, 0, 8'h80, 8'h00);
        check("plan_rd80", last_rdata, 8'h77);
        drop_req();

        // cpu abandons a miss: the line is still filled
        @(negedge CLK);
        READ = 1'b1; ADDRESS = 8'h3C;
        repeat (2) @(negedge CLK);
        READ = 1'b0;
        guard = 0;
        #1;
        while ((o_dbg_state != 2'd0) && guard < 100) begin
            @(negedge CLK); #1; guard++;
        end
        check("abandon_returns_idle", o_dbg_state, 2'd0);
        m_valid[7] = 1'b1; m_tag[7] = 3'd1; m_dirty[7] = 1'b0;
        do_access(0, 0, 8'h3C, 8'h00);
        check("abandon_line_hit", last_saw_rd, 0);
        drop_req();

        // reset in the middle of a fetch
        @(negedge CLK);
        READ = 1'b1; ADDRESS = 8'h10;
        guard = 0;
        #1;
        while (!MEM_READ && guard < 20) begin
            @(negedge CLK); #1; guard++;
        end
        check("pre_reset_fetch", MEM_READ, 1);
        @(negedge CLK);
        RESET = 1'b0;
        READ  = 1'b0;
        @(posedge CLK);
        #1;
        check("reset_drops_mem_read", MEM_READ, 0);
        check("reset_state_idle", o_dbg_state, 2'd0);
        @(negedge CLK);
        RESET = 1'b1;
        model_reset();
        do_access(0, 0, 8'h10, 8'h00);
        check("post_reset_miss_10", last_saw_rd, 1);
        do_access(0, 0, 8'h05, 8'h00);
        check("post_reset_miss_05", last_saw_rd, 1);

        // randomized accesses on a small tag pool to force conflicts
        for (int n = 0; n < 250; n++) begin
            logic [7:0] a;
            bit         wr;
            bit         both;
            a       = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            wr      = 1'($urandom_range(0, 1));
            both    = wr && ($urandom_range(0, 7) == 0);
            mem_lat = $urandom_range(1, 6);
            do_access(wr, both, a, 8'($urandom));
            if ($urandom_range(0, 3) == 0) drop_req();
        end
        drop_req();
        @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache placed between the cpu load/store port and data_memory.
- Responds to the cpu on the same READ/WRITE/ADDRESS/WRITEDATA/READDATA/BUSYWAIT protocol that data_memory currently serves.
- Initiates block-sized transfers to main memory (4-byte blocks, word-wide data) on a READ/WRITE/BUSYWAIT handshake.
- Hits complete with zero stall; misses stall the cpu through BUSYWAIT.

Parameters:
INDEX_BITS, 3, set index width; sets = 2^INDEX_BITS, tag = 6-INDEX_BITS bits (address = tag|index|2-bit byte offset)

Ports:
CLK  input  1  clock, all state updates on posedge
RESET  input  1  synchronous, active-low reset, sampled on posedge CLK
READ  input  1  cpu load request, held until BUSYWAIT low
WRITE  input  1  cpu store request, held until BUSYWAIT low
ADDRESS  input  8  cpu byte address
WRITEDATA  input  8  cpu store data
READDATA  output  8  load data
BUSYWAIT  output  1  cpu stall
MEM_READ  output  1  block fetch request
MEM_WRITE  output  1  block write-back request
MEM_ADDRESS  output  6  block address {tag,index}
MEM_WRITEDATA  output  32  write-back block, byte 0 in [7:0]
MEM_READDATA  input  32  fetched block, byte 0 in [7:0]
MEM_BUSYWAIT  input  1  memory busy

Behaviour:
- Per-set storage: valid, dirty, tag, 32-bit block.
- RESET low at posedge: all valid and dirty bits cleared, state = IDLE, MEM_READ = MEM_WRITE = 0.
  - Tag and data contents are don't-care after reset.
  - Reset mid-miss aborts the transfer. MEM_READ/MEM_WRITE fall on that same edge. No array write occurs.
- hit = valid[index] & (tag[index] == ADDRESS tag).

States:
- IDLE:
  - BUSYWAIT = (READ|WRITE) & !hit, combinational.
  - Read hit: READDATA = block byte selected by offset, combinational, valid in the same cycle.
  - Write hit: at posedge, the selected byte gets WRITEDATA and dirty = 1.
  - Miss with dirty line: next state WRITEBACK. Miss with clean or invalid line: next state FETCH.
  - READ and WRITE both high: treated as WRITE.
- WRITEBACK:
  - Outputs: MEM_WRITE = 1, MEM_ADDRESS = {stored tag, index}, MEM_WRITEDATA = stored block.
  - Completion = MEM_BUSYWAIT low at any posedge except the first posedge in the state. The first edge is ignored to cover memory's registered busy.
  - On completion: next state FETCH.
- FETCH:
  - Outputs: MEM_READ = 1, MEM_ADDRESS = {ADDRESS tag, index}.
  - Same completion rule as WRITEBACK.
  - On the completion edge: block = MEM_READDATA, tag updated, valid = 1, dirty = 0. Next state IDLE.
- In WRITEBACK and FETCH, BUSYWAIT = 1. MEM_READ and MEM_WRITE are never high together. Both are 0 in IDLE.
- After a miss returns to IDLE, the held request hits and completes that cycle. Miss penalty is 1 + memory latency (+ write-back latency if dirty).
- READDATA = 0 whenever there is no read hit in IDLE.
- cpu drops its request mid-miss: the transfer still completes, the line is filled, and the cache returns to IDLE.
- Address fields are computed from the live ADDRESS; the cpu holds ADDRESS stable while BUSYWAIT is high.

Test Plan:
- Reset, then READ addr 0x05 with memory block 0x44332211 and a 5-cycle busy model -> MEM_READ high with MEM_ADDRESS=0x01; BUSYWAIT high until fill; then READDATA=0x22 with BUSYWAIT low the next cycle.
- Repeat READ 0x05, then READ 0x07 -> zero-stall hits returning 0x22 and 0x44; no MEM_READ pulse.
- WRITE 0xAB to 0x05 (hit) -> BUSYWAIT stays low; dirty set; a later READ 0x05 returns 0xAB.
- READ 0x25 (same index 1, tag 1), line dirty -> WRITEBACK with MEM_ADDRESS=0x01 and MEM_WRITEDATA=0x4433AB11, then FETCH with MEM_ADDRESS=0x09, then hit.
- WRITE 0x77 to 0x80 (clean miss) -> FETCH only, with no MEM_WRITE; after fill the byte is written and dirty = 1.
- RESET low during FETCH -> MEM_READ low at the next edge; a following READ of the same address misses again because all lines are invalid.
